rtc_button_cond: RTL and testbench

Conditions the three raw time-set push buttons of the real-time clock into clean, single-cycle increment pulses for the HH:MM:SS counters. It sits directly upstream of the clock/display driver: pins in, `inc_pulse` out. Each button is synchronised, debounced on a 1 kHz tick and, optionally, auto-repeated while held. Pulses are produced only while manual set mode is selected.

---
 rtl/rtc_pkg.sv | 28 ++
 rtl/rtc_btn_channel.sv | 172 +++++++++++++++++
 rtl/rtc_button_cond.sv | 63 ++++++
 tb/tb_rtc_button_cond.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ============================================================================
// Module : rtc_pkg
// Brief  : Shared types and constants for the RTC time-set button conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ARMED  = 2'd2,
    REPEAT = 2'd3
  } btn_state_e;

  localparam int NUM_BTN = 3;
  localparam int BTN_SEC = 0;
  localparam int BTN_MIN = 1;
  localparam int BTN_HR  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_btn_channel.sv
// ============================================================================
// Module : rtc_btn_channel
// Brief  : One button: 2-FF sync, tick-based debounce, set-mode FSM and
//          optional auto-repeat (enabled by RTC_BTN_AUTOREPEAT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_btn_channel
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn_n,
  input  logic i_man_sw,
  output logic o_pulse,
  output logic o_held
);

  localparam logic [7:0] c_DB_LAST = 8'(DEBOUNCE_MS - 1);

  logic [1:0] r_sync;
  logic [7:0] r_db_cnt;
  logic       r_held;
  logic       r_held_d;
  logic       r_pulse;
  logic       w_sample;
  logic       w_rise;
  logic       w_pulse_nxt;

  btn_state_e r_state;
  btn_state_e w_state_nxt;

  assign w_sample = r_sync[1];
  assign w_rise   = r_held & ~r_held_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], ~i_btn_n};
    end
  end

  // Any agreeing sample restarts the run, so only an unbroken run of
  // DEBOUNCE_MS disagreeing ticks flips the debounced state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt <= 8'd0;
      r_held   <= 1'b0;
      r_held_d <= 1'b0;
    end else begin
      r_held_d <= r_held;
      if (w_sample == r_held) begin
        r_db_cnt <= 8'd0;
      end else if (i_tick) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_held   <= w_sample;
          r_db_cnt <= 8'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 8'd1;
        end
      end
    end
  end

`ifdef RTC_BTN_AUTOREPEAT_EN
  localparam int c_HOLD_MAX = max_int(REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
  localparam logic [c_HOLD_W-1:0] c_DELAY = c_HOLD_W'(REPEAT_DELAY_MS);
  localparam logic [c_HOLD_W-1:0] c_RATE  = c_HOLD_W'(REPEAT_RATE_MS);

  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic [c_HOLD_W-1:0] w_hold_inc;
  logic                r_tick_d;

  assign w_hold_inc = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + c_HOLD_W'(1);

  // Hold timing runs one cycle behind the debouncer so a release landing on
  // a repeat boundary is seen before the repeat would fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt <= '0;
      r_tick_d   <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
      r_tick_d   <= i_tick;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
`ifdef RTC_BTN_AUTOREPEAT_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    case (r_state)
      IDLE: begin
`ifdef RTC_BTN_AUTOREPEAT_EN
        w_hold_nxt = '0;
`endif
        if (w_rise) begin
          w_pulse_nxt = i_man_sw;
          w_state_nxt = i_man_sw ? ARMED : LOCKED;
        end
      end
      LOCKED: begin
        if (!r_held) w_state_nxt = IDLE;
      end
      ARMED: begin
        if (!r_held) begin
          w_state_nxt = IDLE;
        end else if (!i_man_sw) begin
          w_state_nxt = LOCKED;
        end
`ifdef RTC_BTN_AUTOREPEAT_EN
        else if (r_tick_d) begin
          if (w_hold_inc == c_DELAY) begin
            w_pulse_nxt = 1'b1;
            w_hold_nxt  = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
`endif
      end
`ifdef RTC_BTN_AUTOREPEAT_EN
      REPEAT: begin
        if (!r_held) begin
          w_state_nxt = IDLE;
        end else if (!i_man_sw) begin
          w_state_nxt = LOCKED;
        end else if (r_tick_d) begin
          if (w_hold_inc == c_RATE) begin
            w_pulse_nxt = 1'b1;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule

`default_nettype wire

// File: rtl/rtc_button_cond.sv
// ============================================================================
// Module : rtc_button_cond
// Brief  : Three-button time-set conditioner: shared 1 kHz tick plus one
//          channel per button. Auto-repeat built when RTC_BTN_AUTOREPEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_button_cond
  import rtc_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] push_but,
  input  logic               man_sw,
  output logic [NUM_BTN-1:0] inc_pulse,
  output logic [NUM_BTN-1:0] btn_held
);

  localparam int c_DIV = CLK_HZ / TICK_HZ;
  localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);

  logic [c_TW-1:0] r_tick_cnt;
  logic            w_tick;

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    rtc_btn_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_btn_n  (push_but[i]),
      .i_man_sw (man_sw),
      .o_pulse  (inc_pulse[i]),
      .o_held   (btn_held[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_button_cond.sv
// ============================================================================
// Module : tb_rtc_button_cond
// Brief  : Self-checking bench for rtc_button_cond (honours RTC_BTN_AUTOREPEAT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtc_button_cond;

  localparam int CLK_HZ = 10000;
  localparam int TICK_HZ = 1000;
  localparam int DEB_MS = 4;
  localparam int DLY_MS = 20;
  localparam int RATE_MS = 5;
  localparam int TP = CLK_HZ / TICK_HZ;
`ifdef RTC_BTN_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] push_but = 3'b111;
  logic       man_sw = 1'b0;
  logic [2:0] inc_pulse;
  logic [2:0] btn_held;

  int n_assert = 0;
  int n_fail = 0;
  int pcnt[3] = '{default: 0};
  int wide[3] = '{default: 0};
  int base[3] = '{default: 0};
  logic [2:0] prev = 3'b000;

  always #5 clk = ~clk;

  rtc_button_cond #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_MS     (DEB_MS),
    .REPEAT_DELAY_MS (DLY_MS),
    .REPEAT_RATE_MS  (RATE_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_but  (push_but),
    .man_sw    (man_sw),
    .inc_pulse (inc_pulse),
    .btn_held  (btn_held)
  );

  // Pulse monitor: counts strobes and flags any strobe longer than one clk.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (inc_pulse[i] === 1'b1) pcnt[i]++;
      if (inc_pulse[i] === 1'b1 && prev[i] === 1'b1) wide[i]++;
    end
    prev = inc_pulse;
  end

  // Reference: one pulse on press, then repeats at DLY, DLY+RATE, ... ticks
  // of debounced hold, strictly before the debounced release.
  function automatic int exp_pulses(input int held_ticks, input bit man);
    int n;
    if (!man) return 0;
    n = 1;
    if (RPT) for (int k = DLY_MS; k < held_ticks; k += RATE_MS) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) base[i] = pcnt[i];
  endtask

  function automatic int got(input int ch);
    return pcnt[ch] - base[ch];
  endfunction

  task automatic wait_held(input int ch, input logic v, input int lim, output int c);
    c = 0;
    while (btn_held[ch] !== v && c < lim) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int ch;
    int len;
    bit m;

    rst = 1'b0;
    push_but = 3'b111;
    man_sw = 1'b1;
    step(3);
    check("reset_inc_pulse", inc_pulse, 0);
    check("reset_btn_held", btn_held, 0);
    rst = 1'b1;
    step(5);

    // Clean press on minutes, 10 ticks long
    step($urandom_range(0, 9));
    snap();
    push_but[rtc_pkg::BTN_MIN] = 1'b0;
    wait_held(1, 1'b1, 60, c);
    check("press_held_rise", btn_held[1], 1);
    check("press_latency_in_window", (c >= 32 && c <= 44), 1);
    step(10 * TP - c);
    push_but[1] = 1'b1;
    step(28);
    check("held_before_release_debounce", btn_held[1], 1);
    step(22);
    check("held_after_release_debounce", btn_held[1], 0);
    check("press_pulse_count", got(1), 1);
    check("press_pulse_width", wide[1], 0);
    step(20);

    // Long hold on seconds: auto-repeat train (or single pulse)
    snap();
    push_but[rtc_pkg::BTN_SEC] = 1'b0;
    step(60 * TP);
    push_but[0] = 1'b1;
    step(70);
    check("hold60_pulse_count", got(0), exp_pulses(60, 1'b1));
    check("hold60_pulse_width", wide[0], 0);

    // Bounce on hours: 2-tick glitches, then stable
    snap();
    for (int k = 0; k < 3; k++) begin
      push_but[rtc_pkg::BTN_HR] = 1'b0;
      step(2 * TP);
      push_but[2] = 1'b1;
      step(2 * TP);
    end
    check("bounce_no_pulse", got(2), 0);
    check("bounce_not_held", btn_held[2], 0);
    push_but[2] = 1'b0;
    step(10 * TP);
    check("bounce_stable_pulse", got(2), 1);
    push_but[2] = 1'b1;
    step(70);

    // Mode gating: press in run mode, switch to set mode while held
    man_sw = 1'b0;
    snap();
    push_but[0] = 1'b0;
    step(100);
    man_sw = 1'b1;
    step(200);
    push_but[0] = 1'b1;
    step(70);
    check("locked_no_pulse", got(0), 0);
    snap();
    push_but[0] = 1'b0;
    step(100);
    push_but[0] = 1'b1;
    step(70);
    check("repress_pulse", got(0), 1);

    // Drop set mode mid-hold: pulses stop at once
    snap();
    push_but[0] = 1'b0;
    step(32 * TP);
    check("pre_drop_pulses", got(0), exp_pulses(28, 1'b1));
    snap();
    man_sw = 1'b0;
    step(30 * TP);
    push_but[0] = 1'b1;
    step(70);
    check("drop_stops_pulses", got(0), 0);
    man_sw = 1'b1;

    // Simultaneous press on all three channels
    snap();
    push_but = 3'b000;
    c = 0;
    while (inc_pulse == 3'b000 && c < 80) begin
      step(1);
      c++;
    end
    check("simul_pulse", inc_pulse, 3'b111);
    step(1);
    check("simul_one_clk", inc_pulse, 3'b000);
    step(60);
    push_but = 3'b111;
    step(70);
    check("simul_counts", got(0) + got(1) + got(2), 3);

    // Randomized single presses against the reference
    for (int n = 0; n < 6; n++) begin
      ch = $urandom_range(0, 2);
      len = $urandom_range(6, 70);
      m = ($urandom_range(0, 3) != 0);
      man_sw = m;
      step($urandom_range(0, 9));
      snap();
      push_but[ch] = 1'b0;
      step(len * TP);
      push_but[ch] = 1'b1;
      step(70);
      check($sformatf("rand%0d_ch%0d_len%0d_man%0d", n, ch, len, m), got(ch), exp_pulses(len, m));
      check($sformatf("rand%0d_other_channels", n), got(0) + got(1) + got(2) - got(ch), 0);
    end
    man_sw = 1'b1;
    step(10);

    // Reset mid-hold, button still held afterwards
    push_but = 3'b110;
    wait_held(0, 1'b1, 60, c);
    check("prereset_held", btn_held[0], 1);
    step(50);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_inc_pulse", inc_pulse, 0);
    check("async_reset_btn_held", btn_held, 0);
    @(negedge clk);
    step(2);
    rst = 1'b1;
    snap();
    wait_held(0, 1'b1, 60, c);
    check("post_reset_held", btn_held[0], 1);
    check("post_reset_latency_in_window", (c >= 35 && c <= 45), 1);
    step(60);
    check("post_reset_pulse", got(0), 1);
    push_but = 3'b111;
    step(70);
    check("pulse_width_all", wide[0] + wide[1] + wide[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
